// File: rtl/cache_lookup.sv
// cache_lookup: single-cycle set-associative tag lookup with per-set true-LRU
// age tracking and a valid/ready registered response.
// Optional build macro: CACHE_LOOKUP_MULTIHIT_CHK_EN enables the multi-hit
// error flag (resp_err); without it resp_err is tied low.
module cache_lookup #(
    parameter int WAYS   = 4,
    parameter int TAG_W  = 3,
    parameter int DATA_W = 32,
    parameter int SETS   = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   req_valid,
    output logic                                   req_ready,
    input  logic [TAG_W-1:0]                       req_tag,
    input  logic [$clog2(SETS)-1:0]                req_idx,
    input  logic [WAYS*(1+TAG_W+DATA_W)-1:0]       ways_in,
    output logic                                   resp_valid,
    input  logic                                   resp_ready,
    output logic                                   resp_hit,
    output logic [WAYS-1:0]                        resp_way,
    output logic [DATA_W-1:0]                      resp_data,
    output logic [WAYS-1:0]                        resp_victim,
    output logic                                   resp_err
);

    localparam int ENTRY_W = 1 + TAG_W + DATA_W;
    localparam int AGE_W   = $clog2(WAYS);
    localparam int IDX_W   = $clog2(SETS);
    localparam logic [AGE_W-1:0] LRU_AGE = AGE_W'(WAYS - 1);

    // Age state: one permutation of 0..WAYS-1 per set, 0 = most recently used.
    logic [AGE_W-1:0]   age_q [SETS][WAYS];

    logic [AGE_W-1:0]   cur_age [WAYS];
    logic [AGE_W-1:0]   new_age [WAYS];
    logic [ENTRY_W-1:0] entry;
    logic [WAYS-1:0]    hit_vec;
    logic [WAYS-1:0]    inval_vec;
    logic [AGE_W-1:0]   hit_idx;
    logic [AGE_W-1:0]   inval_idx;
    logic [AGE_W-1:0]   lru_idx;
    logic [AGE_W-1:0]   touch_idx;
    logic [DATA_W-1:0]  hit_data;
    logic               hit_any;
    logic               multi_hit;
    logic               accept;

    // Response register (stage p1)
    logic               vld_p1;
    logic               hit_p1;
    logic [WAYS-1:0]    way_p1;
    logic [DATA_W-1:0]  data_p1;
    logic [WAYS-1:0]    victim_p1;
    logic               err_p1;

    assign req_ready = !vld_p1 || resp_ready;
    assign accept    = req_valid && req_ready;
    assign hit_any   = |hit_vec;

`ifdef CACHE_LOOKUP_MULTIHIT_CHK_EN
    // More than one bit set: clearing the lowest set bit leaves something.
    assign multi_hit = (hit_vec & (hit_vec - WAYS'(1))) != '0;
`else
    assign multi_hit = 1'b0;
`endif

    // Tag compare per way; descending scan so the lowest index wins each priority pick.
    always_comb begin
        entry     = '0;
        hit_vec   = '0;
        inval_vec = '0;
        hit_idx   = '0;
        inval_idx = '0;
        lru_idx   = '0;
        hit_data  = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            entry        = ways_in[i*ENTRY_W +: ENTRY_W];
            cur_age[i]   = age_q[req_idx][i];
            hit_vec[i]   = entry[ENTRY_W-1] && (entry[ENTRY_W-2 -: TAG_W] == req_tag);
            inval_vec[i] = !entry[ENTRY_W-1];
            if (hit_vec[i]) begin
                hit_idx  = AGE_W'(i);
                hit_data = entry[DATA_W-1:0];
            end
            if (inval_vec[i]) begin
                inval_idx = AGE_W'(i);
            end
            if (cur_age[i] == LRU_AGE) begin
                lru_idx = AGE_W'(i);
            end
        end
    end

    // Way to promote to MRU: the hit way, else an empty way, else the LRU way.
    always_comb begin
        if (hit_any) begin
            touch_idx = hit_idx;
        end else if (|inval_vec) begin
            touch_idx = inval_idx;
        end else begin
            touch_idx = lru_idx;
        end
        for (int i = 0; i < WAYS; i++) begin
            if (AGE_W'(i) == touch_idx) begin
                new_age[i] = '0;
            end else if (cur_age[i] < cur_age[touch_idx]) begin
                new_age[i] = cur_age[i] + AGE_W'(1);
            end else begin
                new_age[i] = cur_age[i];
            end
        end
    end

    // Age storage: reset to identity order, update only the accessed set on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    age_q[s][w] <= AGE_W'(w);
                end
            end
        end else if (accept) begin
            for (int w = 0; w < WAYS; w++) begin
                age_q[req_idx][w] <= new_age[w];
            end
        end
    end

    // Response register: load on accept, drop on take, hold while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            hit_p1    <= 1'b0;
            way_p1    <= '0;
            data_p1   <= '0;
            victim_p1 <= '0;
            err_p1    <= 1'b0;
        end else if (accept) begin
            vld_p1    <= 1'b1;
            hit_p1    <= hit_any;
            way_p1    <= hit_any ? (WAYS'(1) << hit_idx) : '0;
            data_p1   <= hit_any ? hit_data : '0;
            victim_p1 <= hit_any ? '0 : (WAYS'(1) << touch_idx);
            err_p1    <= multi_hit;
        end else if (resp_ready) begin
            vld_p1    <= 1'b0;
        end
    end

    assign resp_valid  = vld_p1;
    assign resp_hit    = hit_p1;
    assign resp_way    = way_p1;
    assign resp_data   = data_p1;
    assign resp_victim = victim_p1;
    assign resp_err    = err_p1;

    // IDX_W kept for readers; req_idx width is derived from SETS directly.
    logic [IDX_W-1:0] unused_idx_w;
    assign unused_idx_w = req_idx;

endmodule

// File: tb/tb_cache_lookup.sv
// tb_cache_lookup: directed-vector bench for cache_lookup (default parameters).
module tb_cache_lookup;

    localparam int WAYS   = 4;
    localparam int TAG_W  = 3;
    localparam int DATA_W = 32;
    localparam int SETS   = 8;
    localparam int ENTRY_W = 1 + TAG_W + DATA_W;

`ifdef CACHE_LOOKUP_MULTIHIT_CHK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     req_valid;
    logic                     req_ready;
    logic [TAG_W-1:0]         req_tag;
    logic [2:0]               req_idx;
    logic [WAYS*ENTRY_W-1:0]  ways_in;
    logic                     resp_valid;
    logic                     resp_ready;
    logic                     resp_hit;
    logic [WAYS-1:0]          resp_way;
    logic [DATA_W-1:0]        resp_data;
    logic [WAYS-1:0]          resp_victim;
    logic                     resp_err;

    int checks   = 0;
    int failures = 0;

    cache_lookup #(.WAYS(WAYS), .TAG_W(TAG_W), .DATA_W(DATA_W), .SETS(SETS)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_tag(req_tag), .req_idx(req_idx), .ways_in(ways_in),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_hit(resp_hit), .resp_way(resp_way), .resp_data(resp_data),
        .resp_victim(resp_victim), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    function automatic logic [ENTRY_W-1:0] ent(input logic v, input logic [TAG_W-1:0] t,
                                               input logic [DATA_W-1:0] d);
        return {v, t, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_resp(input string tag, input logic v, input logic h,
                            input logic [WAYS-1:0] w, input logic [DATA_W-1:0] d,
                            input logic [WAYS-1:0] vic, input logic e);
        chk({tag, ".valid"},  64'(resp_valid),  64'(v));
        chk({tag, ".hit"},    64'(resp_hit),    64'(h));
        chk({tag, ".way"},    64'(resp_way),    64'(w));
        chk({tag, ".data"},   64'(resp_data),   64'(d));
        chk({tag, ".victim"}, 64'(resp_victim), 64'(vic));
        chk({tag, ".err"},    64'(resp_err),    64'(e));
    endtask

    // Four valid ways with tags 1..4 and data A0..A3.
    function automatic logic [WAYS*ENTRY_W-1:0] full_set();
        return {ent(1'b1, 3'd4, 32'hA3), ent(1'b1, 3'd3, 32'hA2),
                ent(1'b1, 3'd2, 32'hA1), ent(1'b1, 3'd1, 32'hA0)};
    endfunction

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_tag    = '0;
        req_idx    = '0;
        ways_in    = '0;
        resp_ready = 1'b1;

        // Reset state
        tick();
        tick();
        chk_resp("reset", 1'b0, 1'b0, 4'b0000, 32'h0, 4'b0000, 1'b0);
        chk("reset.req_ready", 64'(req_ready), 64'(1));
        rst = 1'b0;

        // Hit on way 2 of set 2
        req_valid = 1'b1;
        req_idx   = 3'd2;
        ways_in   = full_set();
        req_tag   = 3'd3;
        tick();
        chk_resp("hit_way2", 1'b1, 1'b1, 4'b0100, 32'hA2, 4'b0000, 1'b0);

        // Consecutive misses on set 0 walk the LRU order 3,2,1
        req_idx = 3'd0;
        req_tag = 3'd5;
        tick();
        chk_resp("miss0_a", 1'b1, 1'b0, 4'b0000, 32'h0, 4'b1000, 1'b0);
        tick();
        chk_resp("miss0_b", 1'b1, 1'b0, 4'b0000, 32'h0, 4'b0100, 1'b0);
        tick();
        chk("miss0_c.victim", 64'(resp_victim), 64'(4'b0010));

        // Set 2 after the earlier hit: ages 1,2,0,3 -> victims way3 then way1
        req_idx = 3'd2;
        tick();
        chk("miss2_a.victim", 64'(resp_victim), 64'(4'b1000));
        tick();
        chk("miss2_b.victim", 64'(resp_victim), 64'(4'b0010));

        // Lowest invalid way is the victim
        req_idx = 3'd5;
        ways_in = {ent(1'b1, 3'd4, 32'hA3), ent(1'b1, 3'd3, 32'hA2),
                   ent(1'b0, 3'd2, 32'hA1), ent(1'b1, 3'd1, 32'hA0)};
        req_tag = 3'd7;
        tick();
        chk_resp("inval_victim", 1'b1, 1'b0, 4'b0000, 32'h0, 4'b0010, 1'b0);

        // Backpressure: two stalled cycles, response and ages frozen
        resp_ready = 1'b0;
        ways_in    = full_set();
        #1;
        chk("stall.req_ready0", 64'(req_ready), 64'(0));
        tick();
        chk_resp("stall1", 1'b1, 1'b0, 4'b0000, 32'h0, 4'b0010, 1'b0);
        chk("stall1.req_ready", 64'(req_ready), 64'(0));
        tick();
        chk_resp("stall2", 1'b1, 1'b0, 4'b0000, 32'h0, 4'b0010, 1'b0);
        resp_ready = 1'b1;
        #1;
        chk("release.req_ready", 64'(req_ready), 64'(1));
        tick();
        chk_resp("take_accept", 1'b1, 1'b0, 4'b0000, 32'h0, 4'b1000, 1'b0);

        // Take with no new request empties the register
        req_valid = 1'b0;
        tick();
        chk("drain.valid", 64'(resp_valid), 64'(0));
        tick();
        chk("idle.valid", 64'(resp_valid), 64'(0));

        // Idle cycles left set 5 ages at 2,1,3,0 -> LRU is way2
        req_valid = 1'b1;
        tick();
        chk("miss5_after_idle.victim", 64'(resp_victim), 64'(4'b0100));

        // Hit on highest way
        req_idx = 3'd6;
        req_tag = 3'd4;
        tick();
        chk_resp("hit_way3", 1'b1, 1'b1, 4'b1000, 32'hA3, 4'b0000, 1'b0);

        // Multiple hits resolve to lowest way; invalid matching way ignored
        req_idx = 3'd3;
        req_tag = 3'd6;
        ways_in = {ent(1'b1, 3'd1, 32'hD3), ent(1'b1, 3'd6, 32'hD2),
                   ent(1'b0, 3'd6, 32'hD1), ent(1'b1, 3'd6, 32'hD0)};
        tick();
        chk_resp("multihit", 1'b1, 1'b1, 4'b0001, 32'hD0, 4'b0000, ERR_EN);

        // Tag only matches an invalid way -> miss, that way is the victim
        req_idx = 3'd4;
        req_tag = 3'd2;
        ways_in = {ent(1'b1, 3'd5, 32'hE3), ent(1'b1, 3'd6, 32'hE2),
                   ent(1'b0, 3'd2, 32'hE1), ent(1'b1, 3'd7, 32'hE0)};
        tick();
        chk_resp("inval_match", 1'b1, 1'b0, 4'b0000, 32'h0, 4'b0010, 1'b0);

        // Reset while holding a response, with an accept pending in the reset cycle
        req_idx    = 3'd1;
        req_tag    = 3'd0;
        ways_in    = full_set();
        resp_ready = 1'b0;
        tick();
        chk("pre_rst.valid", 64'(resp_valid), 64'(1));
        rst        = 1'b1;
        resp_ready = 1'b1;
        tick();
        chk_resp("mid_rst", 1'b0, 1'b0, 4'b0000, 32'h0, 4'b0000, 1'b0);
        chk("mid_rst.req_ready", 64'(req_ready), 64'(1));
        rst = 1'b0;

        // Ages restored: set 0 victims 3 then 2, set 1 victim 3
        req_idx = 3'd0;
        req_tag = 3'd5;
        tick();
        chk("post_rst0_a.victim", 64'(resp_victim), 64'(4'b1000));
        tick();
        chk("post_rst0_b.victim", 64'(resp_victim), 64'(4'b0100));
        req_idx = 3'd1;
        tick();
        chk("post_rst1.victim", 64'(resp_victim), 64'(4'b1000));

        req_valid = 1'b0;
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cache_lookup.md
CACHE_LOOKUP -- requirements
Module: cache_lookup

Interface
REQ-001 Parameter WAYS, default 4, associativity; power of two, at least 2.
REQ-002 Parameter TAG_W, default 3, tag width in bits.
REQ-003 Parameter DATA_W, default 32, line data width in bits.
REQ-004 Parameter SETS, default 8, number of sets tracked for replacement; power of two; IDX_W = log2(SETS).
REQ-005 Entry layout SHALL be ENTRY_W = 1+TAG_W+DATA_W: MSB = valid, next TAG_W bits = tag, low DATA_W bits = data.
REQ-006 clk  input  1  single clock, all state on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 req_valid  input  1  lookup request present.
REQ-009 req_ready  output  1  lookup accepted this cycle when high with req_valid.
REQ-010 req_tag  input  TAG_W  tag to compare.
REQ-011 req_idx  input  IDX_W  set index selecting replacement state.
REQ-012 ways_in  input  WAYS*ENTRY_W  set entries; way i at bits [i*ENTRY_W +: ENTRY_W].
REQ-013 resp_valid  output  1  response held in output register.
REQ-014 resp_ready  input  1  consumer takes response.
REQ-015 resp_hit  output  1  tag matched a valid way.
REQ-016 resp_way  output  WAYS  one-hot hitting way; zero on miss.
REQ-017 resp_data  output  DATA_W  data of hitting way; zero on miss.
REQ-018 resp_victim  output  WAYS  one-hot replacement way on miss; zero on hit.
REQ-019 resp_err  output  1  multiple ways hit (see Configuration).

Function
REQ-020 Way i hits when its valid bit is 1 and its tag equals req_tag; invalid ways never hit.
REQ-021 Accept = req_valid && req_ready; req_ready SHALL equal !resp_valid || resp_ready (combinational).
REQ-022 Latency SHALL be 1 cycle: fields computed from the accepted request appear with resp_valid the next cycle.
REQ-023 Response fields SHALL hold stable while resp_valid && !resp_ready; resp_valid clears after a take with no new accept.
REQ-024 Take and new accept in the same cycle SHALL overwrite the response register with no bubble.
REQ-025 Each set SHALL hold WAYS age counters of log2(WAYS) bits; age 0 = MRU, WAYS-1 = LRU; ages in a set always form a permutation.
REQ-026 On accepted hit to way h: ages less than age[h] increment, age[h] becomes 0, others unchanged.
REQ-027 On accepted miss: victim = lowest-index invalid way if any, else the way with age WAYS-1; ages then update as a hit to the victim.
REQ-028 Age update SHALL commit at the edge ending the accept cycle; a following accept to the same set sees updated ages.
REQ-029 No age state SHALL change on cycles without an accept.
REQ-030 Multiple hits SHALL resolve to the lowest-index hitting way for resp_way, resp_data and age update.

Reset
REQ-031 While rst is high: resp_valid, resp_hit, resp_err = 0; resp_way, resp_victim, resp_data = 0; req_ready = 1 after the reset edge.
REQ-032 Reset SHALL initialise every set's ages to age[i] = i (way WAYS-1 is LRU).
REQ-033 Reset mid-operation SHALL discard any held response and any accept in the reset cycle.

Configuration
REQ-034 Macro CACHE_LOOKUP_MULTIHIT_CHK_EN defined: resp_err = 1 with a response whose hit vector has more than one bit set, else 0.
REQ-035 Macro undefined: resp_err SHALL be tied 0 and no multi-hit logic built; REQ-030 resolution unchanged.

Verification
REQ-036 After reset, idx 2, all ways valid, tags 1,2,3,4, req_tag 3 -> next cycle resp_hit=1, resp_way=0100, resp_data=way2 data, resp_victim=0000.
REQ-037 After reset, idx 0, all valid, no tag match -> miss, resp_victim=1000; immediate repeat miss -> resp_victim=0100.
REQ-038 idx 5, way1 invalid, others valid, no match -> resp_victim=0010, resp_way=0000, resp_data=0.
REQ-039 Hold resp_ready=0 two cycles with req_valid=1 -> req_ready=0, response stable, ages unchanged; resp_ready=1 -> take and accept same cycle.
REQ-040 ways 0 and 2 both valid with req_tag -> resp_way=0001; resp_err=1 with CACHE_LOOKUP_MULTIHIT_CHK_EN, 0 without.
REQ-041 rst asserted while resp_valid=1 -> next cycle resp_valid=0, all outputs 0, set ages back to 0,1,2,3.
